cplx_vec_loader: RTL and testbench
==================================

# cplx_vec_loader

Streaming operand loader for the complex matrix multiplier datapath. It accepts complex operand pairs (a, b) one element per cycle over a valid/ready handshake and packs N consecutive elements into a frame. Each completed frame is presented as full parallel vectors to the multiplier stage directly downstream. Ping-pong banking lets one frame fill while the previous one is held for the consumer.

## Interface
- N, 4, elements per frame (vector length); N ≥ 2
- W, 8, signed element width (two's complement)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all frame state; priority over every handshake
- in_valid  in  1  upstream element valid
- in_ready  out  1  loader can accept an element
- in_a_re, in_a_im, in_b_re, in_b_im  in  W each  signed operand element
- in_last  in  1  marks the final element of an upstream frame
- out_valid  out  1  full frame available
- out_ready  in  1  downstream accepts the frame
- out_a_re, out_a_im, out_b_re, out_b_im  out  N*W each  packed vectors; element k occupies bits [k*W+W-1 : k*W]
- err_short  out  1  one-cycle pulse: frame closed by in_last before N elements
- err_long  out  1  one-cycle pulse: frame closed at N elements without in_last

## Operation
- Two banks, B0 and B1. Each bank is either FILL or FULL.
- Pointers: wr_bank, rd_bank (1 bit each), and elem_idx (0..N-1).
- Reset/flush state: both banks FILL with all storage zero, wr_bank = rd_bank = 0, elem_idx = 0, err pulses low.
- in_ready = (bank[wr_bank] == FILL). out_valid = (bank[rd_bank] == FULL). out_* are driven from bank[rd_bank].
- Input accept (in_valid && in_ready): store the element at elem_idx in bank[wr_bank].
- Frame close occurs when elem_idx == N-1 or when in_last is set. On close:
  - bank goes FULL, elem_idx returns to 0, wr_bank toggles.
  - Short frame (in_last with elem_idx < N-1): unwritten elements remain zero; err_short pulses.
  - Element N-1 accepted without in_last: err_long pulses. The next element starts a new frame.
- Output accept (out_valid && out_ready): bank[rd_bank] is cleared to all-zero data and returns to FILL; rd_bank toggles.
- Simultaneous input close on one bank and output release of the other bank: both take effect in the same edge.
- Arithmetic: none. Data passes bit-exact, sign preserved.

## Timing
- All outputs are registered state or pure decodes of registered state. No combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises on the edge that accepts the closing element (visible the following cycle).
- Sustained throughput (ping-pong): one frame per N cycles with out_ready held high and no bubbles.
- out_* and out_valid are held stable while out_valid && !out_ready.
- in_ready falls the cycle after both banks are FULL. It rises the cycle after an output accept.
- flush mid-frame: the partial frame is discarded with no error pulse. in_ready = 1 and out_valid = 0 on the next cycle.
- Asynchronous reset mid-operation: same end state as flush, applied immediately.

## Configuration
- CPLX_LOADER_PINGPONG_EN
  - Defined: two banks, as described above.
  - Undefined: single bank; wr_bank and rd_bank are tied to 0. in_ready is low from frame close until the cycle after the output accept, so sustained throughput drops to one frame per N+1 cycles. All other behaviour is identical.

## Test plan
- Single frame: reset, then stream a = (1+2j, -3+4j, 5-6j, -128+127j) with b = a, in_last on element 3. Required: out_valid on the next cycle; out_a_re = {-128, 5, -3, 1} packed; no error pulse.
- Short frame: stream 2 elements (7+0j, -1-1j) with in_last on element 1. Required: err_short pulses once; elements 2 and 3 read zero.
- Long frame: stream 4 elements with in_last never set. Required: frame closes after element 3; err_long pulses once; the 5th element lands at index 0 of the other bank.
- Backpressure: hold out_ready = 0 and stream 3 frames. Required: two frames buffered; in_ready low from then on; out_* stable; after one out_ready pulse, in_ready rises the next cycle and the 3rd frame completes.
- Throughput: stream 8 back-to-back frames with out_ready = 1. Required: 32 accepts in 32 cycles with the PINGPONG macro defined; 40 cycles without it.
- Flush/reset: assert flush after 2 elements of a frame with one frame pending. Required: out_valid = 0 and in_ready = 1 next cycle; no error pulses. Repeat using rst_n asserted mid-cycle.

Source files
------------

// File: rtl/cplx_vec_loader.sv
`default_nettype none
// ============================================================================
// Module : cplx_vec_loader
// Packs N complex operand pairs per frame into banked parallel vectors for the
// multiplier stage. Define CPLX_LOADER_PINGPONG_EN for two-bank ping-pong.
// Rev    : 1.0
// ============================================================================
module cplx_vec_loader #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a_re,
    input  logic [W-1:0]   in_a_im,
    input  logic [W-1:0]   in_b_re,
    input  logic [W-1:0]   in_b_im,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_a_re,
    output logic [N*W-1:0] out_a_im,
    output logic [N*W-1:0] out_b_re,
    output logic [N*W-1:0] out_b_im,
    output logic           err_short,
    output logic           err_long
);

    localparam int              IDX_W      = $clog2(N);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N - 1);
    localparam logic            c_FILL     = 1'b0;
    localparam logic            c_FULL     = 1'b1;
`ifdef CPLX_LOADER_PINGPONG_EN
    localparam logic            c_PINGPONG = 1'b1;
`else
    localparam logic            c_PINGPONG = 1'b0;
`endif

    logic             r_bank_st     [2];
    logic             w_bank_st_nxt [2];
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic             w_wr_bank_nxt;
    logic             w_rd_bank_nxt;
    logic [IDX_W-1:0] r_elem_idx;
    logic [IDX_W-1:0] w_elem_idx_nxt;
    logic             r_err_short;
    logic             r_err_long;
    logic             w_err_short_nxt;
    logic             w_err_long_nxt;

    logic [N*W-1:0]   r_a_re [2];
    logic [N*W-1:0]   r_a_im [2];
    logic [N*W-1:0]   r_b_re [2];
    logic [N*W-1:0]   r_b_im [2];

    logic             w_in_acc;
    logic             w_out_acc;
    logic             w_at_end;
    logic             w_close;

    assign w_in_acc  = in_valid && in_ready;
    assign w_out_acc = out_valid && out_ready;
    assign w_at_end  = (r_elem_idx == c_LAST_IDX);
    assign w_close   = w_in_acc && (w_at_end || in_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_st[0] <= c_FILL;
            r_bank_st[1] <= c_FILL;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_elem_idx   <= '0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
        end else begin
            r_bank_st[0] <= w_bank_st_nxt[0];
            r_bank_st[1] <= w_bank_st_nxt[1];
            r_wr_bank    <= w_wr_bank_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_elem_idx   <= w_elem_idx_nxt;
            r_err_short  <= w_err_short_nxt;
            r_err_long   <= w_err_long_nxt;
        end
    end

    // Next-state logic; a close and a release never target the same bank
    always_comb begin
        w_bank_st_nxt[0] = r_bank_st[0];
        w_bank_st_nxt[1] = r_bank_st[1];
        w_wr_bank_nxt    = r_wr_bank;
        w_rd_bank_nxt    = r_rd_bank;
        w_elem_idx_nxt   = r_elem_idx;
        w_err_short_nxt  = 1'b0;
        w_err_long_nxt   = 1'b0;
        if (flush) begin
            w_bank_st_nxt[0] = c_FILL;
            w_bank_st_nxt[1] = c_FILL;
            w_wr_bank_nxt    = 1'b0;
            w_rd_bank_nxt    = 1'b0;
            w_elem_idx_nxt   = '0;
        end else begin
            if (w_close) begin
                w_bank_st_nxt[r_wr_bank] = c_FULL;
                w_elem_idx_nxt           = '0;
                w_wr_bank_nxt            = c_PINGPONG & ~r_wr_bank;
                w_err_short_nxt          = in_last && !w_at_end;
                w_err_long_nxt           = w_at_end && !in_last;
            end else if (w_in_acc) begin
                w_elem_idx_nxt = r_elem_idx + 1'b1;
            end
            if (w_out_acc) begin
                w_bank_st_nxt[r_rd_bank] = c_FILL;
                w_rd_bank_nxt            = c_PINGPONG & ~r_rd_bank;
            end
        end
    end

    // Output decode of registered state only
    always_comb begin
        in_ready  = (r_bank_st[r_wr_bank] == c_FILL);
        out_valid = (r_bank_st[r_rd_bank] == c_FULL);
        out_a_re  = r_a_re[r_rd_bank];
        out_a_im  = r_a_im[r_rd_bank];
        out_b_re  = r_b_re[r_rd_bank];
        out_b_im  = r_b_im[r_rd_bank];
        err_short = r_err_short;
        err_long  = r_err_long;
    end

    // Bank storage: cleared on release so short frames read zero in the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_a_re[b] <= '0;
                r_a_im[b] <= '0;
                r_b_re[b] <= '0;
                r_b_im[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (flush || (w_out_acc && (r_rd_bank == b[0]))) begin
                    r_a_re[b] <= '0;
                    r_a_im[b] <= '0;
                    r_b_re[b] <= '0;
                    r_b_im[b] <= '0;
                end else if (w_in_acc && (r_wr_bank == b[0])) begin
                    for (int k = 0; k < N; k++) begin
                        if (r_elem_idx == k[IDX_W-1:0]) begin
                            r_a_re[b][k*W +: W] <= in_a_re;
                            r_a_im[b][k*W +: W] <= in_a_im;
                            r_b_re[b][k*W +: W] <= in_b_re;
                            r_b_im[b][k*W +: W] <= in_b_im;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cplx_vec_loader.sv
`default_nettype none
// Testbench for cplx_vec_loader: a table of hand-computed frame vectors plus
// directed backpressure, long-frame, throughput, flush and reset sequences.
module tb_cplx_vec_loader;

    localparam int N = 4;
    localparam int W = 8;
`ifdef CPLX_LOADER_PINGPONG_EN
    localparam int NB       = 2;
    localparam int TPUT_CYC = 32;
`else
    localparam int NB       = 1;
    localparam int TPUT_CYC = 40;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N*W-1:0] out_a_re, out_a_im, out_b_re, out_b_im;
    logic           err_short, err_long;

    cplx_vec_loader #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_re   (in_a_re),
        .in_a_im   (in_a_im),
        .in_b_re   (in_b_re),
        .in_b_im   (in_b_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a_re  (out_a_re),
        .out_a_im  (out_a_im),
        .out_b_re  (out_b_re),
        .out_b_im  (out_b_im),
        .err_short (err_short),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int n_short = 0, n_long = 0, n_acc = 0, cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (err_short) n_short = n_short + 1;
        if (err_long)  n_long  = n_long + 1;
        if (in_valid && in_ready) n_acc = n_acc + 1;
    end

    typedef struct {
        int             len;
        bit             last;
        logic [W-1:0]   are [4];
        logic [W-1:0]   aim [4];
        logic [W-1:0]   bre [4];
        logic [W-1:0]   bim [4];
        logic [N*W-1:0] x_are, x_aim, x_bre, x_bim;
        int             x_short, x_long;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Generated frame content for the directed sequences
    function automatic logic [W-1:0] fe(input int f, input int k, input int sel);
        case (sel)
            0:       return W'(f * 16 + k);
            1:       return W'(f * 16 + k + 8);
            2:       return W'(255 - f * 16 - k);
            default: return W'(f * 16 + k + 100);
        endcase
    endfunction

    function automatic logic [N*W-1:0] pk_n(input int f, input int sel, input int cnt);
        logic [N*W-1:0] v = '0;
        for (int k = 0; k < cnt; k++) v[k*W +: W] = fe(f, k, sel);
        return v;
    endfunction

    task automatic send_elem(input logic [W-1:0] ar, input logic [W-1:0] ai,
                             input logic [W-1:0] br, input logic [W-1:0] bi,
                             input logic last);
        bit ok = 1'b0;
        in_a_re = ar; in_a_im = ai; in_b_re = br; in_b_im = bi;
        in_last = last; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            n_vec++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_gen(input int f, input int k, input logic last);
        send_elem(fe(f, k, 0), fe(f, k, 1), fe(f, k, 2), fe(f, k, 3), last);
    endtask

    task automatic send_frame(input int f);
        for (int k = 0; k < N; k++) send_gen(f, k, k == N - 1);
    endtask

    task automatic chk_frame(input string name, input int f, input int cnt);
        chk({name, ".out_valid"}, out_valid, 1);
        chk({name, ".a_re"}, out_a_re, pk_n(f, 0, cnt));
        chk({name, ".a_im"}, out_a_im, pk_n(f, 1, cnt));
        chk({name, ".b_re"}, out_b_re, pk_n(f, 2, cnt));
        chk({name, ".b_im"}, out_b_im, pk_n(f, 3, cnt));
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, l0, a0, t0, t1;

        vecs[0].len = 4; vecs[0].last = 1'b1;
        vecs[0].are = '{8'h01, 8'hFD, 8'h05, 8'h80};
        vecs[0].aim = '{8'h02, 8'h04, 8'hFA, 8'h7F};
        vecs[0].bre = vecs[0].are; vecs[0].bim = vecs[0].aim;
        vecs[0].x_are = 32'h8005_FD01; vecs[0].x_aim = 32'h7FFA_0402;
        vecs[0].x_bre = 32'h8005_FD01; vecs[0].x_bim = 32'h7FFA_0402;
        vecs[0].x_short = 0; vecs[0].x_long = 0;

        vecs[1].len = 2; vecs[1].last = 1'b1;
        vecs[1].are = '{8'h07, 8'hFF, 8'h00, 8'h00};
        vecs[1].aim = '{8'h00, 8'hFF, 8'h00, 8'h00};
        vecs[1].bre = vecs[1].are; vecs[1].bim = vecs[1].aim;
        vecs[1].x_are = 32'h0000_FF07; vecs[1].x_aim = 32'h0000_FF00;
        vecs[1].x_bre = 32'h0000_FF07; vecs[1].x_bim = 32'h0000_FF00;
        vecs[1].x_short = 1; vecs[1].x_long = 0;

        vecs[2].len = 4; vecs[2].last = 1'b0;
        vecs[2].are = '{8'h0A, 8'h0C, 8'h0E, 8'h10};
        vecs[2].aim = '{8'h0B, 8'h0D, 8'h0F, 8'h11};
        vecs[2].bre = '{8'hFF, 8'h00, 8'h7F, 8'h01};
        vecs[2].bim = '{8'h00, 8'hFF, 8'h80, 8'h01};
        vecs[2].x_are = 32'h100E_0C0A; vecs[2].x_aim = 32'h110F_0D0B;
        vecs[2].x_bre = 32'h017F_00FF; vecs[2].x_bim = 32'h0180_FF00;
        vecs[2].x_short = 0; vecs[2].x_long = 1;

        vecs[3].len = 3; vecs[3].last = 1'b1;
        vecs[3].are = '{8'hFE, 8'h04, 8'h06, 8'h00};
        vecs[3].aim = '{8'h03, 8'hFB, 8'h07, 8'h00};
        vecs[3].bre = '{8'h01, 8'h02, 8'h03, 8'h00};
        vecs[3].bim = '{8'hFF, 8'hFE, 8'hFD, 8'h00};
        vecs[3].x_are = 32'h0006_04FE; vecs[3].x_aim = 32'h0007_FB03;
        vecs[3].x_bre = 32'h0003_0201; vecs[3].x_bim = 32'h00FD_FEFF;
        vecs[3].x_short = 1; vecs[3].x_long = 0;

        vecs[4].len = 1; vecs[4].last = 1'b1;
        vecs[4].are = '{8'h80, 8'h00, 8'h00, 8'h00};
        vecs[4].aim = '{8'h80, 8'h00, 8'h00, 8'h00};
        vecs[4].bre = '{8'h7F, 8'h00, 8'h00, 8'h00};
        vecs[4].bim = '{8'h7F, 8'h00, 8'h00, 8'h00};
        vecs[4].x_are = 32'h0000_0080; vecs[4].x_aim = 32'h0000_0080;
        vecs[4].x_bre = 32'h0000_007F; vecs[4].x_bim = 32'h0000_007F;
        vecs[4].x_short = 1; vecs[4].x_long = 0;

        // Reset state
        #12;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_a_re", out_a_re, 0);
        chk("rst.err", {err_short, err_long}, 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames, each popped after checking
        for (int i = 0; i < 5; i++) begin
            s0 = n_short; l0 = n_long;
            for (int k = 0; k < vecs[i].len; k++)
                send_elem(vecs[i].are[k], vecs[i].aim[k], vecs[i].bre[k], vecs[i].bim[k],
                          vecs[i].last && (k == vecs[i].len - 1));
            @(negedge clk); #1;
            chk($sformatf("v%0d.out_valid", i), out_valid, 1);
            chk($sformatf("v%0d.a_re", i), out_a_re, vecs[i].x_are);
            chk($sformatf("v%0d.a_im", i), out_a_im, vecs[i].x_aim);
            chk($sformatf("v%0d.b_re", i), out_b_re, vecs[i].x_bre);
            chk($sformatf("v%0d.b_im", i), out_b_im, vecs[i].x_bim);
            @(posedge clk); #1;
            pop();
            @(negedge clk); #1;
            chk($sformatf("v%0d.popped", i), out_valid, 0);
            chk($sformatf("v%0d.err_short", i), n_short - s0, vecs[i].x_short);
            chk($sformatf("v%0d.err_long", i), n_long - l0, vecs[i].x_long);
            @(posedge clk); #1;
        end

        // Long frame: the next element starts a new frame at index 0
        s0 = n_short; l0 = n_long;
        for (int k = 0; k < N; k++) send_gen(10, k, 1'b0);
        @(negedge clk); #1;
        chk_frame("long", 10, N);
        @(posedge clk); #1;
`ifdef CPLX_LOADER_PINGPONG_EN
        send_gen(11, 0, 1'b0);
        @(negedge clk); #1;
        chk("long.held_a_re", out_a_re, pk_n(10, 0, N));
        @(posedge clk); #1;
        pop();
`else
        pop();
        send_gen(11, 0, 1'b0);
`endif
        for (int k = 1; k < N; k++) send_gen(11, k, k == N - 1);
        @(negedge clk); #1;
        chk_frame("after_long", 11, N);
        chk("long.err_long", n_long - l0, 1);
        chk("long.err_short", n_short - s0, 0);
        @(posedge clk); #1;
        pop();

        // Backpressure: NB frames buffer, the next one waits for a release
        for (int f = 0; f < NB; f++) send_frame(f);
        @(negedge clk); #1;
        chk("bp.in_ready_low", in_ready, 0);
        chk_frame("bp.head", 0, N);
        fork
            send_frame(NB);
            begin
                for (int t = 0; t < 3; t++) begin
                    @(negedge clk); #1;
                    chk("bp.stall_in_ready", in_ready, 0);
                    chk("bp.stable_a_re", out_a_re, pk_n(0, 0, N));
                    chk("bp.stable_b_im", out_b_im, pk_n(0, 3, N));
                end
                @(posedge clk); #1;
                pop();
                @(negedge clk); #1;
                chk("bp.in_ready_rise", in_ready, 1);
            end
        join
        @(negedge clk); #1;
        for (int f = 1; f <= NB; f++) begin
            chk_frame($sformatf("bp.f%0d", f), f, N);
            @(posedge clk); #1;
            pop();
            @(negedge clk); #1;
        end
        chk("bp.drained", out_valid, 0);
        @(posedge clk); #1;

        // Throughput with a consumer that never stalls
        s0 = n_short; l0 = n_long; a0 = n_acc;
        out_ready = 1'b1;
        send_gen(30, 0, 1'b0);
        t0 = cyc;
        for (int k = 1; k < N; k++) send_gen(30, k, k == N - 1);
        for (int f = 1; f < 8; f++) send_frame(30 + f);
        t1 = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (in_ready) begin
                t1 = cyc;
                break;
            end
        end
        chk("tput.accepts", n_acc - a0, 8 * N);
        chk("tput.cycles", t1 - t0, TPUT_CYC);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk); #1;
        chk("tput.drained", out_valid, 0);
        chk("tput.no_err", (n_short - s0) + (n_long - l0), 0);
        @(posedge clk); #1;

        // Flush mid-frame with a frame pending where banking allows it
        s0 = n_short; l0 = n_long;
`ifdef CPLX_LOADER_PINGPONG_EN
        send_frame(20);
`endif
        send_gen(21, 0, 1'b0);
        send_gen(21, 1, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
        chk("flush.out_valid", out_valid, 0);
        chk("flush.in_ready", in_ready, 1);
        chk("flush.no_err", (n_short - s0) + (n_long - l0), 0);
        @(posedge clk); #1;
        send_gen(22, 0, 1'b1);
        @(negedge clk); #1;
        chk_frame("flush.fresh", 22, 1);
        @(posedge clk); #1;
        pop();
        chk("flush.fresh_short", n_short - s0, 1);

        // Asynchronous reset mid-frame
        s0 = n_short; l0 = n_long;
`ifdef CPLX_LOADER_PINGPONG_EN
        send_frame(23);
`endif
        send_gen(24, 0, 1'b0);
        send_gen(24, 1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.in_ready", in_ready, 1);
        chk("arst.out_a_re", out_a_re, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst.no_err", (n_short - s0) + (n_long - l0), 0);
        send_gen(25, 0, 1'b1);
        @(negedge clk); #1;
        chk_frame("arst.fresh", 25, 1);
        @(posedge clk); #1;
        pop();
        @(negedge clk); #1;
        chk("arst.drained", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
